// File: rtl/uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_param                                                 |
// | Purpose  : Oversampling asynchronous serial receiver. It validates the   |
// |            start bit at mid-bit and samples the data, parity and stop    |
// |            bits at mid-bit. It flags frame and parity errors for each    |
// |            character and delivers characters over valid/ready with       |
// |            overrun detection.                                            |
// | Options  : define UART_RX_FIFO_EN to replace the single holding register |
// |            with a FIFO_DEPTH-entry FIFO.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_overrun
);

  localparam int c_samp_w = $clog2(CLKS_PER_BIT);
  localparam int c_bit_w  = $clog2(DATA_BITS + 1);
  localparam int c_ent_w  = DATA_BITS + 2;

  localparam logic [c_samp_w-1:0] c_half_last = c_samp_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_samp_w-1:0] c_full_last = c_samp_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame_cfg
      $error("uart_rx_param: illegal frame configuration");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_cfg
      $error("uart_rx_param: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_sync2, r_line_prev;
  logic                  w_line;
  logic [c_samp_w-1:0]   r_samp_cnt;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_err, r_frame_err;
  logic                  w_samp_clr, w_start, w_data_smp, w_par_smp, w_stop_smp;
  logic                  w_bit_clr, w_complete;
  logic                  w_par_exp, w_frame_final, w_pop;
  logic [c_ent_w-1:0]    w_char;

  assign w_line = r_sync2;

  // Two-flop synchroniser, plus one more stage to detect the falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_line_prev <= 1'b1;
    end else begin
      r_sync1     <= rxd;
      r_sync2     <= r_sync1;
      r_line_prev <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and per-cycle sampling strobes.
  always_comb begin
    w_state_next = r_state;
    w_samp_clr   = 1'b0;
    w_start      = 1'b0;
    w_data_smp   = 1'b0;
    w_par_smp    = 1'b0;
    w_stop_smp   = 1'b0;
    w_bit_clr    = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_samp_clr = 1'b1;
        // Only a real 1->0 transition starts a frame; a held-low line never does.
        if (r_line_prev && !w_line) begin
          w_state_next = S_START;
          w_start      = 1'b1;
        end
      end
      S_START: begin
        if (r_samp_cnt == c_half_last) begin
          w_samp_clr   = 1'b1;
          w_state_next = w_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_samp_cnt == c_full_last) begin
          w_samp_clr = 1'b1;
          w_data_smp = 1'b1;
          if (r_bit_cnt == c_data_last) begin
            w_bit_clr    = 1'b1;
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (r_samp_cnt == c_full_last) begin
          w_samp_clr   = 1'b1;
          w_par_smp    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (r_samp_cnt == c_full_last) begin
          w_samp_clr = 1'b1;
          w_stop_smp = 1'b1;
          // The character is handed over at the last stop sample, without
          // waiting for the end of the stop bit.
          if (r_bit_cnt == c_stop_last) begin
            w_bit_clr    = 1'b1;
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_par_exp     = (PARITY == 2) ? (^r_shift) : (~^r_shift);
  assign w_frame_final = r_frame_err | (w_stop_smp & ~w_line);
  assign w_char        = {r_par_err, w_frame_final, r_shift};
  assign rx_busy       = (r_state != S_IDLE);
  assign w_pop         = rx_valid & rx_ready;

  // Datapath: sample/bit counters, LSB-first shift register and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_samp_clr || r_samp_cnt == c_full_last) r_samp_cnt <= '0;
      else                                         r_samp_cnt <= r_samp_cnt + 1'b1;
      if (w_bit_clr)                    r_bit_cnt <= '0;
      else if (w_data_smp || w_stop_smp) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_data_smp) r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
      if (w_start) begin
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_par_smp)              r_par_err   <= (w_line != w_par_exp);
      if (w_stop_smp && !w_line)  r_frame_err <= 1'b1;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_overrun;
  logic               w_full, w_push;

  assign w_full = (r_count == c_depth);
  // A full FIFO still accepts a character when the head leaves in the same cycle.
  assign w_push = w_complete & (~w_full | w_pop);

  // Output FIFO: pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_complete & ~w_push;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_char;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_valid = (r_count != '0);
  assign {rx_parity_err, rx_frame_err, rx_data} = r_mem[r_rd_ptr];
  assign rx_overrun = r_overrun;
`else
  logic [c_ent_w-1:0] r_hold;
  logic               r_valid;
  logic               r_overrun;

  // Single holding register; a new character may replace one leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete && (!r_valid || rx_ready)) begin
        r_hold  <= w_char;
        r_valid <= 1'b1;
      end else begin
        if (w_pop)      r_valid   <= 1'b0;
        if (w_complete) r_overrun <= 1'b1;
      end
    end
  end

  assign rx_valid = r_valid;
  assign {rx_parity_err, rx_frame_err, rx_data} = r_hold;
  assign rx_overrun = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_param                                              |
// | Purpose  : Scoreboard bench for uart_rx_param. Instance A uses the       |
// |            default 8N1 framing and instance B uses 7E1 framing.          |
// |            Expected characters are queued by the stimulus and popped by  |
// |            monitors on each valid/ready transfer.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_param;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rxd_b = 1'b1;
  logic       rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] data_a;
  logic       fe_a, pe_a, val_a, busy_a, ovr_a;
  logic [6:0] data_b;
  logic       fe_b, pe_b, val_b, busy_b, ovr_b;

  int checks = 0;
  int failures = 0;
  logic [9:0] q_a[$];   // {parity_err, frame_err, data[7:0]}
  logic [8:0] q_b[$];   // {parity_err, frame_err, data[6:0]}
  int   ovr_cnt_a = 0;
  logic busy_seen_a = 1'b0;
  logic val_seen_a = 1'b0;

  uart_rx_param #(.CLKS_PER_BIT(CPB)) u_dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rx_data(data_a), .rx_frame_err(fe_a),
    .rx_parity_err(pe_a), .rx_valid(val_a), .rx_ready(rdy_a), .rx_busy(busy_a),
    .rx_overrun(ovr_a)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) u_dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rx_data(data_b), .rx_frame_err(fe_b),
    .rx_parity_err(pe_b), .rx_valid(val_b), .rx_ready(rdy_b), .rx_busy(busy_b),
    .rx_overrun(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance n clocks, then settle 1 time unit past the edge before driving.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift a 10-bit frame (start bit in bit 0) onto one of the two lines.
  task automatic send(input int sel, input logic [9:0] bits);
    for (int i = 0; i < 10; i++) begin
      if (sel == 0) rxd_a = bits[i];
      else          rxd_b = bits[i];
      cyc(CPB);
    end
  endtask

  // Monitor A: track activity flags and score every completed transfer.
  always @(negedge clk) begin
    if (ovr_a)  ovr_cnt_a++;
    if (busy_a) busy_seen_a = 1'b1;
    if (val_a)  val_seen_a = 1'b1;
    if (val_a && rdy_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_char actual=%0h required=none", {pe_a, fe_a, data_a});
      end else begin
        chk("a_char", {22'd0, pe_a, fe_a, data_a}, {22'd0, q_a.pop_front()});
      end
    end
  end

  // Monitor B: the 7E1 instance is always ready.
  always @(negedge clk) begin
    if (ovr_b) begin
      checks++;
      failures++;
      $display("FAIL b_overrun actual=1 required=0");
    end
    if (val_b && rdy_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_char actual=%0h required=none", {pe_b, fe_b, data_b});
      end else begin
        chk("b_char", {23'd0, pe_b, fe_b, data_b}, {23'd0, q_b.pop_front()});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  n;
    logic got;

    // Reset state.
    cyc(4);
    @(negedge clk);
    chk("reset_a", {data_a, fe_a, pe_a, val_a, busy_a, ovr_a}, 0);
    chk("reset_b", {data_b, fe_b, pe_b, val_b, busy_b, ovr_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(4);

    // 0xA5, 8N1: rx_valid first seen 156 negedges after the drive (2 sync + 153 + 1).
    q_a.push_back({2'b00, 8'hA5});
    got = 1'b0;
    n = 0;
    fork
      send(0, {1'b1, 8'hA5, 1'b0});
      begin
        while (!got && n < 300) begin
          @(negedge clk);
          n++;
          if (val_a) got = 1'b1;
        end
        chk("a5_latency", n, 156);
        chk("a5_busy_done", {31'd0, busy_a}, 0);
        @(negedge clk);
        chk("a5_valid_pulse", {31'd0, val_a}, 0);
      end
    join
    cyc(4);

    // False start: line low for 4 cycles only.
    busy_seen_a = 1'b0;
    val_seen_a = 1'b0;
    ovr_cnt_a = 0;
    rxd_a = 1'b0;
    cyc(4);
    rxd_a = 1'b1;
    cyc(40);
    chk("false_busy_seen", {31'd0, busy_seen_a}, 1);
    chk("false_no_valid", {31'd0, val_seen_a}, 0);
    chk("false_busy_end", {31'd0, busy_a}, 0);
    chk("false_no_overrun", ovr_cnt_a, 0);

    // 7E1 parity: 0x35 has even weight, so the correct even parity bit is 0.
    q_b.push_back({2'b10, 7'h35});
    send(1, {1'b1, 1'b1, 7'h35, 1'b0});
    q_b.push_back({2'b00, 7'h35});
    send(1, {1'b1, 1'b0, 7'h35, 1'b0});
    q_b.push_back({2'b00, 7'h7F});
    send(1, {1'b1, 1'b1, 7'h7F, 1'b0});
    q_b.push_back({2'b01, 7'h2A});
    send(1, {1'b0, 1'b1, 7'h2A, 1'b0});
    rxd_b = 1'b1;
    cyc(4);

    // Break: 0x00 with a low stop bit, then the line stays low 40 bit times.
    q_a.push_back({2'b01, 8'h00});
    send(0, 10'b0);
    cyc(4);
    busy_seen_a = 1'b0;
    val_seen_a = 1'b0;
    cyc(40 * CPB);
    chk("break_no_busy", {31'd0, busy_seen_a}, 0);
    chk("break_no_valid", {31'd0, val_seen_a}, 0);
    rxd_a = 1'b1;
    cyc(2 * CPB);
    q_a.push_back({2'b00, 8'h5A});
    send(0, {1'b1, 8'h5A, 1'b0});
    cyc(4);

    // Overrun: consumer stalled, two characters arrive.
    rdy_a = 1'b0;
    ovr_cnt_a = 0;
    send(0, {1'b1, 8'h11, 1'b0});
    send(0, {1'b1, 8'h22, 1'b0});
    cyc(4);
`ifdef UART_RX_FIFO_EN
    chk("ovr_count", ovr_cnt_a, 0);
`else
    chk("ovr_count", ovr_cnt_a, 1);
`endif
    @(negedge clk);
    chk("ovr_held", {22'd0, val_a, fe_a, data_a}, {22'd0, 1'b1, 1'b0, 8'h11});
    @(posedge clk); #1;

    // Third frame is cut by reset in its data phase.
    rxd_a = 1'b0;
    cyc(CPB);
    rxd_a = 1'b1;
    cyc(2 * CPB);
    chk("f3_busy", {31'd0, busy_a}, 1);
    rst = 1'b1;
    q_a.delete();
    cyc(2);
    @(negedge clk);
    chk("midreset_a", {data_a, fe_a, pe_a, val_a, busy_a, ovr_a}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_a = 1'b1;
    cyc(CPB);
    q_a.push_back({2'b00, 8'h33});
    send(0, {1'b1, 8'h33, 1'b0});
    cyc(4);

`ifdef UART_RX_FIFO_EN
    // FIFO: five characters into four entries while stalled.
    rdy_a = 1'b0;
    ovr_cnt_a = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_a.push_back({2'b00, 8'(k)});
      send(0, {1'b1, 8'(k), 1'b0});
    end
    cyc(4);
    chk("fifo_ovr_count", ovr_cnt_a, 1);
    rdy_a = 1'b1;
    cyc(10);
`endif

    cyc(10);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
